// File: rtl/axi4s_wrr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_wrr_arbiter_if
// Purpose  : Bundle of LANES_P parallel AXI4-Stream channels. The arbiter uses
//            one instance for its master side (N lanes) and one instance for
//            the merged slave side (a single lane).
// Revision : 1.0 - initial release
// ============================================================================
interface axi4s_wrr_arbiter_if #(
    parameter int LANES_P      = 1,
    parameter int DATA_WIDTH_P = 64,
    parameter int KEEP_WIDTH_P = 8,
    parameter int ID_WIDTH_P   = 4,
    parameter int DEST_WIDTH_P = 4,
    parameter int USER_WIDTH_P = 1
);
    logic [LANES_P-1:0]              tvalid;
    logic [LANES_P-1:0]              tready;
    logic [LANES_P*DATA_WIDTH_P-1:0] tdata;
    logic [LANES_P*KEEP_WIDTH_P-1:0] tkeep;
    logic [LANES_P-1:0]              tlast;
    logic [LANES_P*ID_WIDTH_P-1:0]   tid;
    logic [LANES_P*DEST_WIDTH_P-1:0] tdest;
    logic [LANES_P*USER_WIDTH_P-1:0] tuser;

    // Stream source: drives payload and valid, receives ready.
    modport master (
        output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    // Stream sink: receives payload and valid, drives ready.
    modport slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axi4s_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_wrr_arbiter
// Purpose  : Packet-granular weighted round-robin merge of NR_OF_MASTERS_P
//            AXI4-Stream masters onto one slave port. A master keeps the
//            turn for up to cfg_weight[i] consecutive packets; every packet
//            start costs one arbitration (IDLE_E) cycle.
// Revision : 1.0 - initial release
// ============================================================================
module axi4s_wrr_arbiter #(
    parameter int NR_OF_MASTERS_P  = 4,
    parameter int AXI_DATA_WIDTH_P = 64,
    parameter int AXI_KEEP_WIDTH_P = 8,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int AXI_DEST_WIDTH_P = 4,
    parameter int AXI_USER_WIDTH_P = 1,
    parameter int WEIGHT_WIDTH_P   = 4,
    parameter int CNT_WIDTH_P      = 16
) (
    input  wire logic                                      clk,
    input  wire logic                                      rst_n,
    axi4s_wrr_arbiter_if.slave                             mst_if,
    axi4s_wrr_arbiter_if.master                            slv_if,
    input  wire logic [NR_OF_MASTERS_P-1:0]                cfg_enable,
    input  wire logic [NR_OF_MASTERS_P*WEIGHT_WIDTH_P-1:0] cfg_weight,
    output logic                                           sts_grant_active,
    output logic [$clog2(NR_OF_MASTERS_P)-1:0]             sts_grant_idx,
    output logic [NR_OF_MASTERS_P*CNT_WIDTH_P-1:0]         sts_pkt_cnt
);

    localparam int c_n       = NR_OF_MASTERS_P;
    localparam int c_idx_w   = $clog2(NR_OF_MASTERS_P);
    localparam int c_dw      = AXI_DATA_WIDTH_P;
    localparam int c_kw      = AXI_KEEP_WIDTH_P;
    localparam int c_iw      = AXI_ID_WIDTH_P;
    localparam int c_dsw     = AXI_DEST_WIDTH_P;
    localparam int c_uw      = AXI_USER_WIDTH_P;
    localparam int c_ww      = WEIGHT_WIDTH_P;
    localparam int c_cw      = CNT_WIDTH_P;

    typedef enum logic [0:0] {
        IDLE_E  = 1'b0,
        GRANT_E = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_idx_w-1:0]   ptr_q, ptr_d;
    logic [c_idx_w-1:0]   sel_q, sel_d;
    logic [c_ww-1:0]      credit_q, credit_d;
    logic [c_cw-1:0]      cnt_q [c_n];
    logic [c_cw-1:0]      cnt_d [c_n];

    logic [c_n-1:0]       w_eligible;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_ww-1:0]      w_idx_weight;
    logic [c_idx_w-1:0]   w_next_ptr;
    logic                 w_pkt_done;

    // A master may compete only with a pending beat, enabled and a nonzero weight.
    for (genvar gi = 0; gi < c_n; gi++) begin : g_eligible
        assign w_eligible[gi] = mst_if.tvalid[gi] & cfg_enable[gi]
                              & (cfg_weight[gi*c_ww +: c_ww] != '0);
    end

    // Circular search for the first eligible master, starting at the pointer.
    always_comb begin
        logic [c_idx_w:0]   sum;
        logic [c_idx_w-1:0] cand;
        w_found = 1'b0;
        w_idx   = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < c_n; k++) begin
            sum = {1'b0, ptr_q} + (c_idx_w+1)'(k);
            if (sum >= (c_idx_w+1)'(c_n)) begin
                sum = sum - (c_idx_w+1)'(c_n);
            end
            cand = sum[c_idx_w-1:0];
            if (!w_found && w_eligible[cand]) begin
                w_found = 1'b1;
                w_idx   = cand;
            end
        end
    end

    assign w_idx_weight = cfg_weight[w_idx*c_ww +: c_ww];

    // Rotation target once the current holder's turn is used up.
    always_comb begin
        w_next_ptr = sel_q + c_idx_w'(1);
        if ({1'b0, sel_q} == (c_idx_w+1)'(c_n - 1)) begin
            w_next_ptr = '0;
        end
    end

    // Output routing: the granted master is connected straight through.
    always_comb begin
        slv_if.tvalid = '0;
        slv_if.tdata  = '0;
        slv_if.tkeep  = '0;
        slv_if.tlast  = '0;
        slv_if.tid    = '0;
        slv_if.tdest  = '0;
        slv_if.tuser  = '0;
        mst_if.tready = '0;
        if (state_q == GRANT_E) begin
            slv_if.tvalid        = mst_if.tvalid[sel_q];
            slv_if.tdata         = mst_if.tdata[sel_q*c_dw +: c_dw];
            slv_if.tkeep         = mst_if.tkeep[sel_q*c_kw +: c_kw];
            slv_if.tlast         = mst_if.tlast[sel_q];
            slv_if.tid           = mst_if.tid[sel_q*c_iw +: c_iw];
            slv_if.tdest         = mst_if.tdest[sel_q*c_dsw +: c_dsw];
            slv_if.tuser         = mst_if.tuser[sel_q*c_uw +: c_uw];
            mst_if.tready[sel_q] = slv_if.tready[0];
        end
    end

    assign w_pkt_done = (state_q == GRANT_E) & mst_if.tvalid[sel_q]
                      & slv_if.tready[0] & mst_if.tlast[sel_q];

    // Next-state: arbitration in IDLE_E, credit/pointer bookkeeping at packet end.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE_E: begin
                if (w_found) begin
                    sel_d   = w_idx;
                    state_d = GRANT_E;
                    // Only the pointer holder with credit left continues its turn;
                    // anyone else (including a holder that forfeited) gets a reload.
                    if (!((w_idx == ptr_q) && (credit_q != '0))) begin
                        credit_d = w_idx_weight;
                        ptr_d    = w_idx;
                    end
                end
            end
            GRANT_E: begin
                if (w_pkt_done) begin
                    cnt_d[sel_q] = cnt_q[sel_q] + c_cw'(1);
                    state_d      = IDLE_E;
                    if (credit_q == c_ww'(1)) begin
                        ptr_d    = w_next_ptr;
                        credit_d = '0;
                    end else begin
                        credit_d = credit_q - c_ww'(1);
                    end
                end
            end
            default: state_d = IDLE_E;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE_E;
            ptr_q    <= '0;
            sel_q    <= '0;
            credit_q <= '0;
            for (int i = 0; i < c_n; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            credit_q <= credit_d;
            for (int i = 0; i < c_n; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sts_grant_active = (state_q == GRANT_E);
    assign sts_grant_idx    = sel_q;

    for (genvar gi = 0; gi < c_n; gi++) begin : g_sts_cnt
        assign sts_pkt_cnt[gi*c_cw +: c_cw] = cnt_q[gi];
    end

endmodule
`default_nettype wire
